// File: rtl/starflux_pkg.sv
// Shared screen geometry, sprite size, colours and the ship drawer state encoding.
// Imported by the ship drawer and its sprite ROM.
package starflux_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int SPRITE_W = 8;
    localparam int SPRITE_H = 8;

    localparam logic [2:0] SHIP_COLOUR = 3'b111;
    localparam logic [2:0] BG_COLOUR   = 3'b000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } draw_state_t;

endpackage

// File: rtl/ship_sprite_rom.sv
// Combinational 8x8 ship mask lookup; bit 7 of each stored row is column 0.
module ship_sprite_rom
    import starflux_pkg::*;
(
    input  logic [2:0] row,
    input  logic [2:0] col,
    output logic       pixel
);

    logic [7:0] row_bits;

    always_comb begin
        row_bits = 8'b0000_0000;
        case (row)
            3'd0: row_bits = 8'b0001_1000;
            3'd1: row_bits = 8'b0011_1100;
            3'd2: row_bits = 8'b0111_1110;
            3'd3: row_bits = 8'b1111_1111;
            3'd4: row_bits = 8'b1111_1111;
            3'd5: row_bits = 8'b0111_1110;
            3'd6: row_bits = 8'b0010_0100;
            3'd7: row_bits = 8'b0100_0010;
            default: row_bits = 8'b0000_0000;
        endcase
        pixel = row_bits[3'd7 - col];
    end

endmodule

// File: rtl/ship_drawer.sv
// Erases the ship at its previous position and redraws it at the new one,
// emitting one registered pixel write per cycle towards the VGA adapter.
module ship_drawer
    import starflux_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] x_in,
    input  logic [7:0] y_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    localparam logic [2:0] LAST_COL = 3'(SPRITE_W - 1);
    localparam logic [2:0] LAST_ROW = 3'(SPRITE_H - 1);

    draw_state_t state;
    logic [7:0]  old_x, old_y;
    logic [7:0]  new_x, new_y;
    logic        drawn;
    logic [2:0]  col, row;

    logic [7:0]  base_x, base_y;
    logic [8:0]  pix_x, pix_y;
    logic        in_bounds;
    logic        mask_bit;
    logic        pix_plot;
    logic        last_pixel;

    ship_sprite_rom u_rom (
        .row   (row),
        .col   (col),
        .pixel (mask_bit)
    );

    // Coordinates are formed 9 bits wide so sprites hanging off the right or
    // bottom edge are clipped instead of wrapping back onto the screen.
    always_comb begin
        base_x     = (state == ERASE) ? old_x : new_x;
        base_y     = (state == ERASE) ? old_y : new_y;
        pix_x      = {1'b0, base_x} + {6'b0, col};
        pix_y      = {1'b0, base_y} + {6'b0, row};
        in_bounds  = (pix_x < 9'(SCREEN_W)) && (pix_y < 9'(SCREEN_H));
        pix_plot   = in_bounds && ((state == ERASE) || mask_bit);
        last_pixel = (col == LAST_COL) && (row == LAST_ROW);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            vga_plot   <= 1'b0;
            vga_x      <= 8'd0;
            vga_y      <= 7'd0;
            vga_colour <= 3'd0;
            old_x      <= 8'd0;
            old_y      <= 8'd0;
            new_x      <= 8'd0;
            new_y      <= 8'd0;
            drawn      <= 1'b0;
            col        <= 3'd0;
            row        <= 3'd0;
        end else begin
            done     <= 1'b0;
            vga_plot <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        new_x <= x_in;
                        new_y <= y_in;
                        col   <= 3'd0;
                        row   <= 3'd0;
                        busy  <= 1'b1;
                        if (!drawn)
                            state <= DRAW;
                        else if ((x_in == old_x) && (y_in == old_y))
                            state <= DONE;
                        else
                            state <= ERASE;
                    end
                end
                ERASE, DRAW: begin
                    // Coordinates only move on a real write, so clipped pixels never show up on vga_x/vga_y.
                    vga_plot <= pix_plot;
                    if (pix_plot) begin
                        vga_x      <= pix_x[7:0];
                        vga_y      <= pix_y[6:0];
                        vga_colour <= (state == ERASE) ? BG_COLOUR : SHIP_COLOUR;
                    end
                    if (col == LAST_COL) begin
                        col <= 3'd0;
                        row <= row + 3'd1;
                    end else begin
                        col <= col + 3'd1;
                    end
                    if (last_pixel) begin
                        row   <= 3'd0;
                        state <= (state == ERASE) ? DRAW : DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    old_x <= new_x;
                    old_y <= new_y;
                    drawn <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ship_drawer.sv
// Directed bench for ship_drawer: a per-cycle model of the erase/draw schedule
// is compared against the DUT, plus hand-computed totals for each update.
module tb_ship_drawer;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic [7:0] x_in, y_in;
    logic       busy, done, vga_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    ship_drawer dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .x_in       (x_in),
        .y_in       (y_in),
        .busy       (busy),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    always #10 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    string mask_art [8] = '{"...##...", "..####..", ".######.", "########",
                            "########", ".######.", "..#..#..", ".#....#."};

    // model state: what the drawer should remember between updates
    int m_old_x = 0, m_old_y = 0;
    bit m_drawn = 0;

    // current operation: 0 = first draw, 1 = erase+draw, 2 = same position
    int op_mode, op_done_t;
    int op_old_x, op_old_y, op_new_x, op_new_y;
    bit op_armed = 0, op_active = 0;
    int t_rel = 0;

    // observations of the current operation
    int plot_count, erase_count, busy_cycles, done_seen_t;
    int first_x, first_y, first_c;
    bit got_first;

    task automatic check_int(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0d)", name, actual, expected, t_rel);
        end
    endtask

    function automatic bit mask_on(input int r, input int c);
        return mask_art[r][c] == "#";
    endfunction

    task automatic expect_at(input int t, output bit eb, output bit ed, output bit ep,
                             output int ex, output int ey, output int ec);
        int k;
        bit erase;
        int bx, by;
        k = -1; erase = 0; bx = 0; by = 0;
        eb = (t < op_done_t);
        ed = (t == op_done_t);
        ep = 0; ex = 0; ey = 0; ec = 0;
        if (op_mode == 1 && t >= 1 && t <= 64) begin
            erase = 1; k = t - 1; bx = op_old_x; by = op_old_y;
        end else if (op_mode == 1 && t >= 65 && t <= 128) begin
            k = t - 65; bx = op_new_x; by = op_new_y;
        end else if (op_mode == 0 && t >= 1 && t <= 64) begin
            k = t - 1; bx = op_new_x; by = op_new_y;
        end
        if (k >= 0) begin
            ex = bx + k % 8;
            ey = by + k / 8;
            ep = (ex < 160) && (ey < 120) && (erase || mask_on(k / 8, k % 8));
            ec = erase ? 0 : 7;
        end
    endtask

    always @(posedge clock) begin
        if (op_armed) begin
            op_armed  = 0;
            op_active = 1;
            t_rel     = 0;
        end else if (op_active) begin
            if (t_rel >= op_done_t + 2) op_active = 0;
            else t_rel++;
        end
    end

    // single compare process: every cycle out of reset is checked against the model
    always @(negedge clock) begin
        bit eb, ed, ep;
        int ex, ey, ec;
        if (resetn) begin
            if (op_active) begin
                expect_at(t_rel, eb, ed, ep, ex, ey, ec);
                check_int("busy", int'(busy), int'(eb));
                check_int("done", int'(done), int'(ed));
                check_int("vga_plot", int'(vga_plot), int'(ep));
                if (ep && vga_plot) begin
                    check_int("vga_x", int'(vga_x), ex);
                    check_int("vga_y", int'(vga_y), ey);
                    check_int("vga_colour", int'(vga_colour), ec);
                end
                if (vga_plot) begin
                    plot_count++;
                    if (vga_colour == 3'd0) erase_count++;
                    if (!got_first) begin
                        got_first = 1;
                        first_x = vga_x; first_y = vga_y; first_c = vga_colour;
                    end
                end
                if (busy) busy_cycles++;
                if (done) done_seen_t = t_rel;
            end else begin
                check_int("idle_busy", int'(busy), 0);
                check_int("idle_done", int'(done), 0);
                check_int("idle_plot", int'(vga_plot), 0);
            end
            check_int("vga_x_range", int'(vga_x < 8'd160), 1);
        end
    end

    task automatic apply_stimulus(input int nx, input int ny);
        @(negedge clock);
        x_in = 8'(nx);
        y_in = 8'(ny);
        start = 1;
        op_old_x = m_old_x; op_old_y = m_old_y;
        op_new_x = nx;      op_new_y = ny;
        if (!m_drawn) begin
            op_mode = 0; op_done_t = 65;
        end else if (nx == m_old_x && ny == m_old_y) begin
            op_mode = 2; op_done_t = 1;
        end else begin
            op_mode = 1; op_done_t = 129;
        end
        m_old_x = nx; m_old_y = ny; m_drawn = 1;
        plot_count = 0; erase_count = 0; busy_cycles = 0; done_seen_t = -1;
        got_first = 0; first_x = -1; first_y = -1; first_c = -1;
        op_armed = 1;
        @(negedge clock);
        start = 0;
    endtask

    task automatic finish_op();
        repeat (op_done_t + 5) @(negedge clock);
        check_int("op_finished", int'(op_active), 0);
    endtask

    task automatic check_output(input string tag);
        check_int({tag, "_busy"}, int'(busy), 0);
        check_int({tag, "_done"}, int'(done), 0);
        check_int({tag, "_plot"}, int'(vga_plot), 0);
        check_int({tag, "_x"}, int'(vga_x), 0);
        check_int({tag, "_y"}, int'(vga_y), 0);
        check_int({tag, "_colour"}, int'(vga_colour), 0);
    endtask

    initial begin
        resetn = 0; start = 0; x_in = 0; y_in = 0;
        repeat (2) @(negedge clock);
        check_output("reset");
        resetn = 1;
        repeat (2) @(negedge clock);

        $display("[TB] first draw at (10,20)");
        apply_stimulus(10, 20);
        finish_op();
        check_int("t1_plots", plot_count, 38);
        check_int("t1_done_t", done_seen_t, 65);
        check_int("t1_busy_cycles", busy_cycles, 65);
        check_int("t1_first_x", first_x, 13);
        check_int("t1_first_y", first_y, 20);
        check_int("t1_first_c", first_c, 7);

        $display("[TB] move to (11,20) with start pulses while busy");
        apply_stimulus(11, 20);
        repeat (10) @(negedge clock);
        start = 1; x_in = 8'd5; y_in = 8'd5;
        @(negedge clock);
        start = 0;
        repeat (60) @(negedge clock);
        start = 1; x_in = 8'd90; y_in = 8'd90;
        @(negedge clock);
        start = 0;
        repeat (op_done_t + 5 - 72) @(negedge clock);
        check_int("op_finished", int'(op_active), 0);
        check_int("t2_plots", plot_count, 102);
        check_int("t2_erase_plots", erase_count, 64);
        check_int("t2_done_t", done_seen_t, 129);
        check_int("t2_first_x", first_x, 10);

        $display("[TB] same position (11,20)");
        apply_stimulus(11, 20);
        finish_op();
        check_int("t3_plots", plot_count, 0);
        check_int("t3_done_t", done_seen_t, 1);

        $display("[TB] move to (30,40) then reset mid draw");
        apply_stimulus(30, 40);
        repeat (94) @(negedge clock);
        #2;
        resetn = 0;
        op_active = 0; op_armed = 0;
        m_drawn = 0; m_old_x = 0; m_old_y = 0;
        #1;
        check_output("async_reset");
        repeat (2) @(negedge clock);
        resetn = 1;
        @(negedge clock);

        $display("[TB] first draw after reset at (155,116)");
        apply_stimulus(155, 116);
        finish_op();
        check_int("t5_plots", plot_count, 14);
        check_int("t5_erase_plots", erase_count, 0);
        check_int("t5_done_t", done_seen_t, 65);
        check_int("t5_first_x", first_x, 158);
        check_int("t5_first_y", first_y, 116);

        $display("[TB] move from clipped corner to (0,0)");
        apply_stimulus(0, 0);
        finish_op();
        check_int("t6_plots", plot_count, 58);
        check_int("t6_erase_plots", erase_count, 20);
        check_int("t6_done_t", done_seen_t, 129);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
